avmm_mul_slave: RTL
===================

AVMM_MUL_SLAVE -- requirements
Module: avmm_mul_slave

Interface
REQ-001 SHALL: clk  input  1  single clock; all logic on posedge.
REQ-002 SHALL: rst_in  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL: address  input  2  Avalon-MM word address (0=A, 1=B, 2=CTRL, 3=R).
REQ-004 SHALL: read  input  1  read request.
REQ-005 SHALL: write  input  1  write request.
REQ-006 SHALL: writedata  input  32  write data.
REQ-007 SHALL: readdata  output  32  read data, registered.
REQ-008 SHALL: readdatavalid  output  1  one-cycle strobe qualifying readdata.
REQ-009 SHALL: waitrequest  output  1  stall; a request is accepted only in a cycle with waitrequest=0.
REQ-010 SHALL: irq  output  1  done interrupt (present only with MUL_IRQ_EN).

Function
REQ-011 SHALL: implement unsigned 32x32 shift-add multiply; R = low 32 bits of A*B; overflow silently discarded.
REQ-012 SHALL: A, B read/write; R read-only; writes to R ignored, accepted without stall.
REQ-013 SHALL: CTRL write bit0=start, bit2=irq_en; CTRL read bit0=busy, bit1=done, bit2=irq_en, others 0.
REQ-014 SHALL: FSM states IDLE, RUN, DONE; IDLE/DONE -> RUN on accepted CTRL write with bit0=1; RUN -> DONE after 32 iterations; DONE -> RUN on next start.
REQ-015 SHALL: start accepted at cycle t -> RUN t+1..t+32, iteration counter 0..31, R valid and done=1 at t+33.
REQ-016 SHALL: operands latched at start; counter wraps 31 -> DONE, never exceeds 31.
REQ-017 SHALL: in RUN, assert waitrequest combinationally for writes to A/B/CTRL and reads of R; reads of A/B/CTRL never stall.
REQ-018 SHALL: stalled request held by master is accepted in first cycle of DONE.
REQ-019 SHALL: accepted read -> readdatavalid=1 and readdata driven exactly one cycle later; readdata 0 otherwise.
REQ-020 SHALL: done cleared by any accepted CTRL write; start with bit0=0 changes only irq_en.
REQ-021 SHALL: simultaneous read and write in one cycle -> write wins, read ignored, no readdatavalid.

Reset
REQ-022 SHALL: on rst_in=0, immediately: FSM=IDLE, A=B=R=0, counter=0, done=0, irq_en=0, readdata=0, readdatavalid=0, irq=0; waitrequest=0.
REQ-023 SHALL: reset mid-RUN abandons operation; no partial R retained.

Configuration
REQ-024 SHALL: macro MUL_IRQ_EN defined -> irq = done AND irq_en, level, cleared with done.
REQ-025 SHALL: MUL_IRQ_EN undefined -> irq port absent, CTRL bit2 reads 0, writes to it ignored.

Structure
REQ-026 SHALL: package mul_pkg holds register offsets (ADDR_A/B/CTRL/R), CTRL bit indices, FSM state enum, iteration count constant 32.
REQ-027 SHALL: datapath in sub-module mul_seq_core (start, a, b -> busy, done, product); avmm_mul_slave holds bus decode, FSM control, registers.

Verification
REQ-028 SHALL: write A=7, B=6, start; poll CTRL -> busy 32 cycles, done at t+33, read R -> 42.
REQ-029 SHALL: A=0xFFFFFFFF, B=2 -> R=0xFFFFFFFE; A=0x10000, B=0x10000 -> R=0.
REQ-030 SHALL: read R one cycle after start -> waitrequest high until DONE, then readdatavalid with correct product.
REQ-031 SHALL: write B=9 during RUN -> stalled, accepted in DONE; current R unaffected; next start uses B=9.
REQ-032 SHALL: rst_in low at iteration 15 -> all outputs zero same cycle, CTRL reads 0 after release.
REQ-033 SHALL: with MUL_IRQ_EN, irq_en=1 -> irq rises at t+33, falls after CTRL write; irq_en=0 -> irq stays 0.

Source files
------------

// File: rtl/mul_pkg.sv
// Shared constants for the Avalon-MM shift-add multiplier: register map, CTRL bits, FSM encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_pkg;

   // Word addresses of the register map
   localparam logic [1:0] ADDR_A    = 2'd0;
   localparam logic [1:0] ADDR_B    = 2'd1;
   localparam logic [1:0] ADDR_CTRL = 2'd2;
   localparam logic [1:0] ADDR_R    = 2'd3;

   // CTRL bit positions (start on write, busy on read share bit 0)
   localparam int CTRL_START  = 0;
   localparam int CTRL_BUSY   = 0;
   localparam int CTRL_DONE   = 1;
   localparam int CTRL_IRQ_EN = 2;

   // One iteration per multiplier bit
   localparam int unsigned      ITER_N   = 32;
   localparam int unsigned      CNT_W    = $clog2(ITER_N);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER_N - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/avmm_mul_slave_if.sv
// Avalon-MM slave bus bundle for the multiplier; irq exists only when MUL_IRQ_EN is defined.
// Latency: n/a (wiring only).
// Backpressure: slave drives waitrequest, master holds its request until it drops.
interface avmm_mul_slave_if;

   logic [1:0]  address;
   logic        read;
   logic        write;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        readdatavalid;
   logic        waitrequest;
`ifdef MUL_IRQ_EN
   logic        irq;

   modport master (output address, read, write, writedata,
                   input  readdata, readdatavalid, waitrequest, irq);
   modport slave  (input  address, read, write, writedata,
                   output readdata, readdatavalid, waitrequest, irq);
`else
   modport master (output address, read, write, writedata,
                   input  readdata, readdatavalid, waitrequest);
   modport slave  (input  address, read, write, writedata,
                   output readdata, readdatavalid, waitrequest);
`endif

endinterface

// File: rtl/mul_seq_core.sv
// Sequential unsigned 32x32 shift-add multiplier keeping the low 32 product bits.
// Latency: start at cycle t -> busy t+1..t+32, done_o high in t+32, product_o updated at t+33.
// Backpressure: none; a start pulse always (re)loads the operands.
module mul_seq_core
   import mul_pkg::*;
(
   input  logic        clk,
   input  logic        rst_in,
   input  logic        start_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] product_o
);

   logic [31:0]      a_q, b_q, acc_q, prod_q;
   logic [31:0]      acc_d;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic             last_w;

   // Partial-product add for the current multiplier bit; bits above 31 fall off
   assign acc_d  = acc_q + (b_q[0] ? a_q : 32'd0);
   assign last_w = busy_q && (cnt_q == CNT_LAST);

   // Iteration state: load on start, then shift multiplicand left / multiplier right
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         a_q    <= '0;
         b_q    <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else if (start_i) begin
         a_q    <= a_i;
         b_q    <= b_i;
         acc_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b1;
      end else if (busy_q) begin
         a_q   <= a_q << 1;
         b_q   <= b_q >> 1;
         acc_q <= acc_d;
         cnt_q <= cnt_q + CNT_W'(1);
         if (last_w) begin
            busy_q <= 1'b0;
         end
      end
   end

   // Result register only changes on the final iteration, so R never shows a partial sum
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         prod_q <= '0;
      end else if (last_w) begin
         prod_q <= acc_d;
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = last_w;
   assign product_o = prod_q;

endmodule

// File: rtl/avmm_mul_slave.sv
// Avalon-MM register front end (A, B, CTRL, R) around mul_seq_core; irq port built only with MUL_IRQ_EN.
// Latency: reads return readdata/readdatavalid one cycle after acceptance; multiply takes 32 cycles.
// Backpressure: waitrequest in RUN for writes to A/B/CTRL and reads of R; released in the first DONE cycle.
module avmm_mul_slave
   import mul_pkg::*;
(
   input  logic            clk,
   input  logic            rst_in,
   avmm_mul_slave_if.slave bus
);

   state_t      state_q, state_d;
   logic [31:0] a_q, b_q;
   logic [31:0] readdata_q, rdata_d;
   logic        rdv_q;
   logic        wait_w, wr_acc, rd_acc, ctrl_wr, start_w;
   logic        core_busy, core_done;
   logic [31:0] core_product;
`ifdef MUL_IRQ_EN
   logic        irq_en_q;
`endif

   // FSM state register
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: a CTRL write without start leaves DONE (done is cleared by any CTRL write)
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start_w) state_d = ST_RUN;
         ST_RUN:  if (core_done) state_d = ST_DONE;
         ST_DONE: begin
            if (start_w) begin
               state_d = ST_RUN;
            end else if (ctrl_wr) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: stall decode and accept strobes; a write in the same cycle as a read wins
   always_comb begin
      wait_w  = 1'b0;
      wr_acc  = 1'b0;
      rd_acc  = 1'b0;
      ctrl_wr = 1'b0;
      start_w = 1'b0;
      if (state_q == ST_RUN) begin
         if (bus.write) begin
            wait_w = (bus.address != ADDR_R);
         end else if (bus.read) begin
            wait_w = (bus.address == ADDR_R);
         end
      end
      wr_acc  = bus.write && !wait_w;
      rd_acc  = bus.read && !bus.write && !wait_w;
      ctrl_wr = wr_acc && (bus.address == ADDR_CTRL);
      start_w = ctrl_wr && bus.writedata[CTRL_START];
   end

   // Operand registers; writes to R are accepted and dropped
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         a_q <= '0;
         b_q <= '0;
      end else if (wr_acc) begin
         if (bus.address == ADDR_A) a_q <= bus.writedata;
         if (bus.address == ADDR_B) b_q <= bus.writedata;
      end
   end

`ifdef MUL_IRQ_EN
   // Interrupt enable, updated by every CTRL write regardless of start
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         irq_en_q <= 1'b0;
      end else if (ctrl_wr) begin
         irq_en_q <= bus.writedata[CTRL_IRQ_EN];
      end
   end

   assign bus.irq = (state_q == ST_DONE) && irq_en_q;
`endif

   // Read mux for the addressed register
   always_comb begin
      rdata_d = '0;
      case (bus.address)
         ADDR_A:    rdata_d = a_q;
         ADDR_B:    rdata_d = b_q;
         ADDR_CTRL: begin
            rdata_d[CTRL_BUSY] = core_busy;
            rdata_d[CTRL_DONE] = (state_q == ST_DONE);
`ifdef MUL_IRQ_EN
            rdata_d[CTRL_IRQ_EN] = irq_en_q;
`endif
         end
         ADDR_R:    rdata_d = core_product;
         default:   rdata_d = '0;
      endcase
   end

   // Registered read response; readdata is held at zero between responses
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         readdata_q <= '0;
         rdv_q      <= 1'b0;
      end else begin
         readdata_q <= rd_acc ? rdata_d : 32'd0;
         rdv_q      <= rd_acc;
      end
   end

   assign bus.readdata      = readdata_q;
   assign bus.readdatavalid = rdv_q;
   assign bus.waitrequest   = wait_w;

   mul_seq_core u_core (
      .clk       (clk),
      .rst_in    (rst_in),
      .start_i   (start_w),
      .a_i       (a_q),
      .b_i       (b_q),
      .busy_o    (core_busy),
      .done_o    (core_done),
      .product_o (core_product)
   );

endmodule
